// File: rtl/de_pkg.sv
// Shared decode definitions for the decode stage: opcode values, fetch-word
// field positions and the opcode-to-control decoder.
package de_pkg;

  localparam int REG_IDX_W = 2;
  localparam int OPC_W     = 4;

  localparam int PC_LSB  = 16;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;
  localparam int COND_BIT = 10;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h5;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h6;
  localparam logic [OPC_W-1:0] OP_SHL = 4'h7;
  localparam logic [OPC_W-1:0] OP_LD  = 4'h8;
  localparam logic [OPC_W-1:0] OP_BR  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BRC = 4'hA;
  localparam logic [OPC_W-1:0] OP_BSR = 4'hB;
  localparam logic [OPC_W-1:0] OP_RET = 4'hC;
  localparam logic [OPC_W-1:0] OP_ST  = 4'hD;
  localparam logic [OPC_W-1:0] OP_LDI = 4'hE;
  localparam logic [OPC_W-1:0] OP_MOV = 4'hF;

  typedef struct packed {
    logic uses_rd;
    logic uses_rs;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        c.uses_rd   = 1'b1;
        c.uses_rs   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_NOT, OP_SHL: begin
        c.uses_rd   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LD: begin
        c.uses_rs   = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
      end
      OP_BR, OP_BRC, OP_BSR, OP_RET: c.branch = 1'b1;
      OP_ST: begin
        c.uses_rd   = 1'b1;
        c.uses_rs   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_LDI: c.reg_write = 1'b1;
      OP_MOV: begin
        c.uses_rs   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/de_regfile.sv
// Architectural register file: one write port, two combinational read ports
// that forward same-cycle write-back data.
module de_regfile
  import de_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rd_data_a = (wb_en && wb_addr == rd_addr_a) ? wb_data : regs[rd_addr_a];
  assign rd_data_b = (wb_en && wb_addr == rd_addr_b) ? wb_data : regs[rd_addr_b];

endmodule

// File: rtl/de_stg.sv
// Decode stage: field extraction, register read with bypass, load-use hazard
// detection and the DE/EX pipeline register.
module de_stg
  import de_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 4,
  parameter int INSTR_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   fe_instruction,
  input  logic                 fe_valid,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 fe_stall,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [OPC_W-1:0]     ex_opcode,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [DATA_W-1:0]    ex_op_a,
  output logic [DATA_W-1:0]    ex_op_b,
  output logic [DATA_W-1:0]    ex_imm,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_branch,
  output logic                 ex_cond
);

  logic [DATA_W-1:0]    pc_p0;
  logic [OPC_W-1:0]     opc_p0;
  logic [REG_IDX_W-1:0] rd_p0;
  logic [REG_IDX_W-1:0] rs_p0;
  logic [DATA_W-1:0]    imm_p0;
  logic                 cond_p0;
  logic [DATA_W-1:0]    op_a_p0;
  logic [DATA_W-1:0]    op_b_p0;
  ctrl_t                ctrl_p0;
  logic                 hazard_p0;

  assign pc_p0   = fe_instruction[PC_LSB +: DATA_W];
  assign opc_p0  = fe_instruction[OPC_LSB +: OPC_W];
  assign rd_p0   = fe_instruction[RD_LSB +: REG_IDX_W];
  assign rs_p0   = fe_instruction[RS_LSB +: REG_IDX_W];
  assign imm_p0  = fe_instruction[IMM_LSB +: DATA_W];
  assign cond_p0 = fe_instruction[COND_BIT];
  assign ctrl_p0 = decode(opc_p0);

  de_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_addr_a (rd_p0),
    .rd_addr_b (rs_p0),
    .rd_data_a (op_a_p0),
    .rd_data_b (op_b_p0)
  );

  // A load in EX cannot forward its result to a dependent instruction here,
  // so that instruction waits one cycle behind a bubble.
  assign hazard_p0 = fe_valid & ex_valid & ex_mem_read & ex_reg_write &
                     ((ctrl_p0.uses_rd & (ex_rd == rd_p0)) |
                      (ctrl_p0.uses_rs & (ex_rd == rs_p0)));
  assign fe_stall  = hazard_p0 & ~flush;

  // ---- DE/EX boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_opcode    <= '0;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_cond      <= 1'b0;
    end else if (flush || hazard_p0) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid     <= fe_valid;
      ex_pc        <= pc_p0;
      ex_opcode    <= opc_p0;
      ex_rd        <= rd_p0;
      ex_op_a      <= op_a_p0;
      ex_op_b      <= op_b_p0;
      ex_imm       <= imm_p0;
      ex_reg_write <= ctrl_p0.reg_write;
      ex_mem_read  <= ctrl_p0.mem_read;
      ex_mem_write <= ctrl_p0.mem_write;
      ex_branch    <= ctrl_p0.branch;
      ex_cond      <= cond_p0;
    end
  end

endmodule

// File: tb/tb_de_stg.sv
// Directed bench for de_stg: a vector table applied one fetch word per cycle,
// plus hand-written reset sequences.
module tb_de_stg;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] fe_instruction;
  logic        fe_valid;
  logic        flush;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        fe_stall;
  logic        ex_valid;
  logic [7:0]  ex_pc;
  logic [3:0]  ex_opcode;
  logic [1:0]  ex_rd;
  logic [7:0]  ex_op_a;
  logic [7:0]  ex_op_b;
  logic [7:0]  ex_imm;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_cond;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_stg dut (
    .clk            (clk),
    .reset          (reset),
    .fe_instruction (fe_instruction),
    .fe_valid       (fe_valid),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .fe_stall       (fe_stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_opcode      (ex_opcode),
    .ex_rd          (ex_rd),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_imm         (ex_imm),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_cond        (ex_cond)
  );

  typedef struct {
    logic [23:0] instr;
    logic        fv, fl, we;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic        stall, vld;
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [7:0]  a, b, imm;
    logic        rw, mr, mw, br, cond;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [23:0] instr, input logic fv, fl, we, input logic [1:0] wa,
    input logic [7:0] wd, input logic stall, vld, input logic [7:0] pc,
    input logic [3:0] op, input logic [1:0] rd, input logic [7:0] a, b, imm,
    input logic rw, mr, mw, br, cond);
    vec_t v;
    v.instr = instr; v.fv = fv; v.fl = fl; v.we = we; v.wa = wa; v.wd = wd;
    v.stall = stall; v.vld = vld; v.pc = pc; v.op = op; v.rd = rd;
    v.a = a; v.b = b; v.imm = imm;
    v.rw = rw; v.mr = mr; v.mw = mw; v.br = br; v.cond = cond;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %h required %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst_valid", idx, {7'd0, ex_valid}, 8'h00);
    chk("rst_pc", idx, ex_pc, 8'h00);
    chk("rst_op", idx, {4'd0, ex_opcode}, 8'h00);
    chk("rst_rd", idx, {6'd0, ex_rd}, 8'h00);
    chk("rst_a", idx, ex_op_a, 8'h00);
    chk("rst_b", idx, ex_op_b, 8'h00);
    chk("rst_imm", idx, ex_imm, 8'h00);
    chk("rst_ctrl", idx, {3'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_cond}, 8'h00);
    chk("rst_stall", idx, {7'd0, fe_stall}, 8'h00);
  endtask

  task automatic drive(input logic [23:0] instr, input logic fv, fl, we,
                       input logic [1:0] wa, input logic [7:0] wd);
    fe_instruction = instr; fe_valid = fv; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  initial begin
    drive(24'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    reset = 1'b1;
    #1;
    chk_all_zero(-1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // instr, fv, fl, we, wa, wd, stall, vld, pc, op, rd, a, b, imm, rw, mr, mw, br, cond
    vecs.push_back(mk(24'h000000,0,0,1,2'd1,8'h05, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h000000,0,0,1,2'd2,8'h03, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h041600,1,0,0,2'd0,8'h00, 0,1, 8'h04,4'h1,2'd1,8'h05,8'h03,8'h00, 1,0,0,0,1));
    vecs.push_back(mk(24'h008400,1,0,0,2'd0,8'h00, 0,1, 8'h00,4'h8,2'd1,8'h05,8'h00,8'h00, 1,1,0,0,1));
    vecs.push_back(mk(24'h021600,1,0,0,2'd0,8'h00, 1,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h021600,1,0,0,2'd0,8'h00, 0,1, 8'h02,4'h1,2'd1,8'h05,8'h03,8'h00, 1,0,0,0,1));
    vecs.push_back(mk(24'h068400,1,0,0,2'd0,8'h00, 0,1, 8'h06,4'h8,2'd1,8'h05,8'h00,8'h00, 1,1,0,0,1));
    vecs.push_back(mk(24'h081B00,1,0,0,2'd0,8'h00, 0,1, 8'h08,4'h1,2'd2,8'h03,8'h00,8'h00, 1,0,0,0,0));
    vecs.push_back(mk(24'h0AF210,1,0,1,2'd2,8'hAA, 0,1, 8'h0A,4'hF,2'd0,8'h00,8'hAA,8'h10, 1,0,0,0,0));
    vecs.push_back(mk(24'h0CD933,1,0,0,2'd0,8'h00, 0,1, 8'h0C,4'hD,2'd2,8'hAA,8'h05,8'h33, 0,0,1,0,0));
    vecs.push_back(mk(24'h0EA440,1,0,0,2'd0,8'h00, 0,1, 8'h0E,4'hA,2'd1,8'h05,8'h00,8'h40, 0,0,0,1,1));
    vecs.push_back(mk(24'h10EC7F,1,0,0,2'd0,8'h00, 0,1, 8'h10,4'hE,2'd3,8'h00,8'h00,8'h7F, 1,0,0,0,1));
    vecs.push_back(mk(24'h000000,0,0,0,2'd0,8'h00, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h126400,1,0,0,2'd0,8'h00, 0,1, 8'h12,4'h6,2'd1,8'h05,8'h00,8'h00, 1,0,0,0,1));
    vecs.push_back(mk(24'h14C000,1,0,0,2'd0,8'h00, 0,1, 8'h14,4'hC,2'd0,8'h00,8'h00,8'h00, 0,0,0,1,0));
    vecs.push_back(mk(24'h168C00,1,0,0,2'd0,8'h00, 0,1, 8'h16,4'h8,2'd3,8'h00,8'h00,8'h00, 1,1,0,0,1));
    vecs.push_back(mk(24'h18F300,1,0,0,2'd0,8'h00, 1,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h18F300,1,0,0,2'd0,8'h00, 0,1, 8'h18,4'hF,2'd0,8'h00,8'h00,8'h00, 1,0,0,0,0));
    vecs.push_back(mk(24'h1A8800,1,0,0,2'd0,8'h00, 0,1, 8'h1A,4'h8,2'd2,8'hAA,8'h00,8'h00, 1,1,0,0,0));
    vecs.push_back(mk(24'h1C1A00,0,0,0,2'd0,8'h00, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h208400,1,0,0,2'd0,8'h00, 0,1, 8'h20,4'h8,2'd1,8'h05,8'h00,8'h00, 1,1,0,0,1));
    vecs.push_back(mk(24'h221600,1,1,0,2'd0,8'h00, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h109020,1,1,0,2'd0,8'h00, 0,0, 8'h00,4'h0,2'd0,8'h00,8'h00,8'h00, 0,0,0,0,0));
    vecs.push_back(mk(24'h109020,1,0,0,2'd0,8'h00, 0,1, 8'h10,4'h9,2'd0,8'h00,8'h00,8'h20, 0,0,0,1,0));
    vecs.push_back(mk(24'h248C00,1,0,0,2'd0,8'h00, 0,1, 8'h24,4'h8,2'd3,8'h00,8'h00,8'h00, 1,1,0,0,1));
    vecs.push_back(mk(24'h26EC01,1,0,0,2'd0,8'h00, 0,1, 8'h26,4'hE,2'd3,8'h00,8'h00,8'h01, 1,0,0,0,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].fv, vecs[i].fl, vecs[i].we, vecs[i].wa, vecs[i].wd);
      #1;
      chk("fe_stall", i, {7'd0, fe_stall}, {7'd0, vecs[i].stall});
      @(posedge clk);
      #1;
      chk("ex_valid", i, {7'd0, ex_valid}, {7'd0, vecs[i].vld});
      if (vecs[i].vld) begin
        chk("ex_pc", i, ex_pc, vecs[i].pc);
        chk("ex_opcode", i, {4'd0, ex_opcode}, {4'd0, vecs[i].op});
        chk("ex_rd", i, {6'd0, ex_rd}, {6'd0, vecs[i].rd});
        chk("ex_op_a", i, ex_op_a, vecs[i].a);
        chk("ex_op_b", i, ex_op_b, vecs[i].b);
        chk("ex_imm", i, ex_imm, vecs[i].imm);
        chk("ex_ctrl", i, {3'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_cond},
            {3'd0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].cond});
      end
    end

    // Reset arriving mid-stall clears the pipe register and drops fe_stall at once.
    @(negedge clk);
    drive(24'h308400, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    drive(24'h321600, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("pre_rst_stall", 100, {7'd0, fe_stall}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero(100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_stall", 101, {7'd0, fe_stall}, 8'h00);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 101, {7'd0, ex_valid}, 8'h01);
    chk("post_rst_pc", 101, ex_pc, 8'h32);
    chk("post_rst_a", 101, ex_op_a, 8'h00);
    chk("post_rst_b", 101, ex_op_b, 8'h00);

    @(negedge clk);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge clk);
    #1;
    chk("idle_valid", 102, {7'd0, ex_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_stg.md
Name: de_stg

Overview:
- Decode stage of the 8-bit RISC pipeline, directly downstream of the fetch stage.
- Consumes the 24-bit fetch word {pc[7:0], instr_hi[7:0], instr_lo[7:0]}.
- Reads a 4x8 register file with write-back bypass and generates control bits.
- Detects load-use hazards (stalls fetch, inserts a bubble), honours flush from execute, and registers all results into the DE/EX pipeline register.

Parameters:
- DATA_W, 8, register/operand width
- NREGS, 4, architectural registers (index width 2)
- INSTR_W, 24, fetch word width {pc, hi, lo}

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous active-high reset
- fe_instruction  in  24  fetch word; [23:16] pc, [15:12] opcode, [11:10] rd/cond, [9:8] rs, [7:0] imm/target
- fe_valid  in  1  fe_instruction holds a real instruction
- flush  in  1  branch redirect from execute; kill decode contents
- wb_en  in  1  register write-back enable
- wb_addr  in  2  write-back register index
- wb_data  in  8  write-back value
- fe_stall  out  1  hold fetch PC and fetch word this cycle (combinational)
- ex_valid  out  1  DE/EX register holds a live instruction
- ex_pc  out  8  pc of the decoded instruction
- ex_opcode  out  4  opcode
- ex_rd  out  2  destination register index
- ex_op_a  out  8  value of R[rd] (first source)
- ex_op_b  out  8  value of R[rs]
- ex_imm  out  8  instr[7:0]
- ex_reg_write  out  1  instruction writes rd
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_branch  out  1  BR/BRZ/BRN/BSR/RET
- ex_cond  out  1  instr[10]; 0 = test Z, 1 = test N (BRZ/BRN only)

Behaviour:
- Opcode map: 0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT, 0111 SHL, 1000 LD, 1001 BR, 1010 BRZ/BRN, 1011 BSR, 1100 RET, 1101 ST, 1110 LDI, 1111 MOV.
- Source usage:
  - ALU 0001-0101 read rd and rs.
  - NOT, SHL read rd.
  - ST reads rd (data) and rs (address).
  - MOV reads rs.
  - LD reads rs.
  - NOP, branches, RET and LDI read none.
- reg_write=1 for 0001-0111, LD, LDI, MOV. mem_read=1 for LD only. mem_write=1 for ST only.
- Register file:
  - 4x8, all registers writable; reset clears all to 0x00.
  - Written at posedge clk when wb_en.
  - Reads are combinational with bypass: if wb_en && wb_addr == index, read wb_data.
- Load-use hazard:
  - hazard = fe_valid & ex_valid & ex_mem_read & ex_reg_write & ((uses_rd & ex_rd == rd) | (uses_rs & ex_rd == rs)).
  - fe_stall = hazard & ~flush.
- Pipeline register update, per posedge clk, in priority order:
  - reset: all ex_* outputs 0, ex_valid 0.
  - flush: ex_valid <= 0; other ex_* fields don't-care but held.
  - hazard: ex_valid <= 0 (bubble); fetch holds, so the same word is re-decoded next cycle.
  - otherwise: capture all decoded fields, ex_valid <= fe_valid.
- Latency: 1 cycle, fe_instruction to ex_*.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ex_valid.
- flush and hazard in the same cycle: flush wins and fe_stall = 0.
- fe_valid=0: no hazard, bubble propagates.
- wb and read of the same register in the same cycle: new value seen (bypass).
- Reset asserted mid-stall: fe_stall drops combinationally once ex_valid clears.
- ex_* outputs are only meaningful when ex_valid=1.
- No X on outputs after reset.

Decomposition:
- Package de_pkg: opcode localparams (OP_NOP..OP_MOV), field bit positions, REG_IDX_W=2, and a decode function returning {uses_rd, uses_rs, reg_write, mem_read, mem_write, branch}.
- Sub-module de_regfile: 4x8, one write port, two read ports, internal bypass, async reset.
- de_stg instantiates de_regfile and holds the hazard logic and the DE/EX register.

Test Plan:
- Reset, then fe_instruction=0x04_1600 (ADD R1,R2) valid, with R1 and R2 preloaded 0x05/0x03 via wb -> next cycle ex_valid=1, ex_pc=0x04, ex_opcode=1, ex_rd=1, ex_op_a=0x05, ex_op_b=0x03, ex_reg_write=1.
- LD R1,(R0) at pc 0x00 (0x00_8400), followed by ADD R1,R2 at pc 0x02 -> cycle after LD: fe_stall=1 for exactly 1 cycle, ex_valid=0 (bubble); the following cycle ADD is captured with ex_pc=0x02.
- LD R1 followed by ADD R2,R3 (no dependency) -> fe_stall never asserts; back-to-back ex_valid=1.
- wb_en=1, wb_addr=2, wb_data=0xAA in the same cycle as decoding MOV R0,R2 -> ex_op_b=0xAA; R2 reads 0xAA afterwards.
- flush=1 together with a hazard condition -> fe_stall=0, next cycle ex_valid=0. Separately, flush alone kills a valid BR (0x10_9020).
- Assert reset asynchronously mid-stream -> ex_valid=0 and all ex_* outputs 0 immediately; register reads return 0x00 after release.
